// File: rtl/spmv_pkg.sv
// Shared types for the sparse matrix-vector row accumulator.
package spmv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/spmv_row_accumulator_if.sv
// Beat-in / row-out stream bundle of the row accumulator, plus its status flags.
interface spmv_row_accumulator_if #(
  parameter int NETWORK_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 16
) ();

  logic                              in_valid;
  logic                              in_ready;
  logic [NETWORK_WIDTH-1:0]          in_lane_valid;
  logic [NETWORK_WIDTH*DATA_WIDTH-1:0] in_data;
  logic [NETWORK_WIDTH*ID_WIDTH-1:0] in_id;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH-1:0]             out_data;
  logic [ID_WIDTH-1:0]               out_id;
  logic                              out_last;
  logic                              busy;
  logic                              err_order;

  modport slave (
    input  in_valid, in_lane_valid, in_data, in_id, in_last, out_ready,
    output in_ready, out_valid, out_data, out_id, out_last, busy, err_order
  );

  modport master (
    output in_valid, in_lane_valid, in_data, in_id, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_id, out_last, busy, err_order
  );

endinterface

// File: rtl/spmv_lane_picker.sv
// Combinational priority picker: lowest set lane of the remaining mask.
module spmv_lane_picker #(
  parameter int NETWORK_WIDTH = 4
) (
  input  logic [NETWORK_WIDTH-1:0]         mask_i,
  output logic [$clog2(NETWORK_WIDTH)-1:0] idx_o,
  output logic                             none_o
);

  always_comb begin
    idx_o = '0;
    // Walk downward so the lowest set index wins.
    for (int i = NETWORK_WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = ($clog2(NETWORK_WIDTH))'(i);
    end
    none_o = ~|mask_i;
  end

endmodule

// File: rtl/spmv_row_accumulator.sv
// Merges per-lane partial sums into per-row totals, one lane per cycle.
// Define SPMV_ROW_ACC_SATURATE_EN for saturating accumulation instead of wrapping.
module spmv_row_accumulator
  import spmv_pkg::*;
#(
  parameter int NETWORK_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 16
) (
  input logic                   clk,
  input logic                   rst,
  spmv_row_accumulator_if.slave bus
);

  localparam int IDX_W = $clog2(NETWORK_WIDTH);

  state_e                              state_q, state_d;
  logic [NETWORK_WIDTH-1:0]            mask_q, mask_d;
  logic [NETWORK_WIDTH*DATA_WIDTH-1:0] data_q, data_d;
  logic [NETWORK_WIDTH*ID_WIDTH-1:0]   id_q, id_d;
  logic                                last_q, last_d;
  logic                                row_open_q, row_open_d;
  logic [DATA_WIDTH-1:0]               acc_q, acc_d;
  logic [ID_WIDTH-1:0]                 row_id_q, row_id_d;
  logic                                out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]               out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]                 out_id_q, out_id_d;
  logic                                out_last_q, out_last_d;
  logic                                err_order_q, err_order_d;

  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_none;
  logic [DATA_WIDTH-1:0]    lane_data [NETWORK_WIDTH];
  logic [ID_WIDTH-1:0]      lane_id   [NETWORK_WIDTH];
  logic [DATA_WIDTH-1:0]    cur_data;
  logic [ID_WIDTH-1:0]      cur_id;
  logic [DATA_WIDTH-1:0]    acc_sum;
  logic [NETWORK_WIDTH-1:0] mask_rem;
  logic                     out_free;
  logic                     emit;
  logic                     in_ready_c;

  spmv_lane_picker #(
    .NETWORK_WIDTH(NETWORK_WIDTH)
  ) u_picker (
    .mask_i(mask_q),
    .idx_o (pick_idx),
    .none_o(pick_none)
  );

  for (genvar gi = 0; gi < NETWORK_WIDTH; gi++) begin : g_lane
    assign lane_data[gi] = data_q[gi*DATA_WIDTH +: DATA_WIDTH];
    assign lane_id[gi]   = id_q[gi*ID_WIDTH +: ID_WIDTH];
  end

  assign cur_data = lane_data[pick_idx];
  assign cur_id   = lane_id[pick_idx];
  assign mask_rem = mask_q & ~({{(NETWORK_WIDTH-1){1'b0}}, 1'b1} << pick_idx);

`ifdef SPMV_ROW_ACC_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH:0] sum_wide;

  always_comb begin
    sum_wide = {acc_q[DATA_WIDTH-1], acc_q} + {cur_data[DATA_WIDTH-1], cur_data};
    // Top two bits disagree only on signed overflow.
    if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      acc_sum = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_sum = sum_wide[DATA_WIDTH-1:0];
    end
  end
`else
  assign acc_sum = acc_q + cur_data;
`endif

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    data_d      = data_q;
    id_d        = id_q;
    last_d      = last_q;
    row_open_d  = row_open_q;
    acc_d       = acc_q;
    row_id_d    = row_id_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    err_order_d = err_order_q;
    in_ready_c  = 1'b0;
    out_free    = ~out_valid_q | bus.out_ready;
    emit        = row_open_q && (cur_id != row_id_q);

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
      end

      SCAN: begin
        if (pick_none) begin
          if (last_q) begin
            state_d = row_open_q ? FLUSH : IDLE;
          end else begin
            in_ready_c = 1'b1;
            state_d    = IDLE;
          end
        end else if (!emit || out_free) begin
          mask_d = mask_rem;
          if (row_open_q && (cur_id < row_id_q)) err_order_d = 1'b1;
          if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_id_d    = row_id_q;
            out_last_d  = 1'b0;
          end
          if (!row_open_q || emit) begin
            row_open_d = 1'b1;
            row_id_d   = cur_id;
            acc_d      = cur_data;
          end else begin
            acc_d = acc_sum;
          end
          if (mask_rem == '0) begin
            if (last_q) begin
              state_d = FLUSH;
            end else begin
              in_ready_c = 1'b1;
              state_d    = IDLE;
            end
          end
        end
      end

      FLUSH: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_id_d    = row_id_q;
          out_last_d  = 1'b1;
          row_open_d  = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A new beat can replace the held one in the same cycle its last lane drains.
    if (in_ready_c && bus.in_valid) begin
      mask_d  = bus.in_lane_valid;
      data_d  = bus.in_data;
      id_d    = bus.in_id;
      last_d  = bus.in_last;
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      data_q      <= '0;
      id_q        <= '0;
      last_q      <= 1'b0;
      row_open_q  <= 1'b0;
      acc_q       <= '0;
      row_id_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      id_q        <= id_d;
      last_q      <= last_d;
      row_open_q  <= row_open_d;
      acc_q       <= acc_d;
      row_id_q    <= row_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      err_order_q <= err_order_d;
    end
  end

  assign bus.in_ready  = in_ready_c & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != IDLE) | row_open_q;
  assign bus.err_order = err_order_q;

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Directed bench for spmv_row_accumulator: hand-computed rows checked with immediate assertions.
module tb_spmv_row_accumulator;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic [15:0] id;
    logic [31:0] data;
    logic        last;
  } row_t;

  row_t rows_q[$];

  spmv_row_accumulator_if #(.NETWORK_WIDTH(4), .DATA_WIDTH(32), .ID_WIDTH(16)) bus ();

  spmv_row_accumulator #(
    .NETWORK_WIDTH(4),
    .DATA_WIDTH   (32),
    .ID_WIDTH     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Capture accepted rows at the falling edge; inputs only change after rising edges.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      row_t r;
      r.id   = bus.out_id;
      r.data = bus.out_data;
      r.last = bus.out_last;
      rows_q.push_back(r);
      $display("row id=%0d data=0x%08h last=%0d", r.id, r.data, r.last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [3:0] m, input logic [63:0] ids,
                           input logic [127:0] dat, input logic lst);
    bit ok;
    ok = 1'b0;
    bus.in_lane_valid = m;
    bus.in_id         = ids;
    bus.in_data       = dat;
    bus.in_last       = lst;
    bus.in_valid      = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("beat_accept", 32'(ok), 32'd1);
    step();
    bus.in_valid = 1'b0;
    $display("beat mask=%b last=%0d accepted=%0d", m, lst, ok);
  endtask

  task automatic wait_rows(input int n);
    for (int c = 0; c < 300 && rows_q.size() < n; c++) @(negedge clk);
    chk("row_count_reached", 32'(rows_q.size() >= n), 32'd1);
  endtask

  task automatic pop_row(input string tag, input logic [15:0] id,
                         input logic [31:0] data, input logic last);
    row_t r;
    if (rows_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      r = rows_q.pop_front();
      chk({tag, "_id"}, 32'(r.id), 32'(id));
      chk({tag, "_data"}, r.data, data);
      chk({tag, "_last"}, 32'(r.last), 32'(last));
    end
  endtask

  task automatic check_drained(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_no_extra_rows"}, 32'(rows_q.size()), 32'd0);
    chk({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, bus.out_data, 32'd0);
    chk({tag, "_out_id"}, 32'(bus.out_id), 32'd0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_err_order"}, 32'(bus.err_order), 32'd0);
  endtask

  logic [31:0] exp_pos_ovf;
  logic [31:0] exp_neg_ovf;

  initial begin
`ifdef SPMV_ROW_ACC_SATURATE_EN
    exp_pos_ovf = 32'h7FFF_FFFF;
    exp_neg_ovf = 32'h8000_0000;
`else
    exp_pos_ovf = 32'h8000_0000;
    exp_neg_ovf = 32'h7FFF_FFFF;
`endif
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_lane_valid = '0;
    bus.in_data       = '0;
    bus.in_id         = '0;
    bus.in_last       = 1'b0;
    bus.out_ready     = 1'b1;

    // Reset state, then in_ready on the first cycle after release.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Four lanes of the same row collapse into one final row.
    step();
    send_beat(4'b1111, {16'd5, 16'd5, 16'd5, 16'd5},
              {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
    wait_rows(1);
    pop_row("same_id", 16'd5, 32'd10, 1'b1);
    check_drained("same_id");

    // Masked-out lane carries junk that must be ignored; row 3 spans two beats.
    step();
    send_beat(4'b1011, {16'd3, 16'h0077, 16'd3, 16'd2},
              {32'd4, 32'd99, 32'd1, 32'd7}, 1'b0);
    send_beat(4'b0001, {16'd0, 16'd0, 16'd0, 16'd3},
              {32'd0, 32'd0, 32'd0, 32'd2}, 1'b1);
    wait_rows(2);
    pop_row("split_r2", 16'd2, 32'd7, 1'b0);
    pop_row("split_r3", 16'd3, 32'd7, 1'b1);
    check_drained("split");

    // Downstream back-pressure: row 10 must hold still while the scan stalls.
    step();
    bus.out_ready = 1'b0;
    send_beat(4'b0111, {16'd0, 16'd12, 16'd11, 16'd10},
              {32'd0, 32'd3, 32'd2, 32'd1}, 1'b1);
    repeat (3) step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_id", 32'(bus.out_id), 32'd10);
      chk("stall_out_data", bus.out_data, 32'd1);
      chk("stall_no_row_taken", 32'(rows_q.size()), 32'd0);
    end
    step();
    bus.out_ready = 1'b1;
    wait_rows(3);
    pop_row("stall_r10", 16'd10, 32'd1, 1'b0);
    pop_row("stall_r11", 16'd11, 32'd2, 1'b0);
    pop_row("stall_r12", 16'd12, 32'd3, 1'b1);
    check_drained("stall");

    // Positive and negative signed overflow.
    step();
    send_beat(4'b1111, {16'd8, 16'd8, 16'd7, 16'd7},
              {32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF}, 1'b1);
    wait_rows(2);
    pop_row("ovf_pos", 16'd7, exp_pos_ovf, 1'b0);
    pop_row("ovf_neg", 16'd8, exp_neg_ovf, 1'b1);
    check_drained("ovf");
    chk("err_order_before", 32'(bus.err_order), 32'd0);

    // Decreasing row id flags err_order but both rows still come out.
    step();
    send_beat(4'b0011, {16'd0, 16'd0, 16'd4, 16'd9},
              {32'd0, 32'd0, 32'd6, 32'd5}, 1'b1);
    wait_rows(2);
    pop_row("order_r9", 16'd9, 32'd5, 1'b0);
    pop_row("order_r4", 16'd4, 32'd6, 1'b1);
    chk("err_order_set", 32'(bus.err_order), 32'd1);
    step();
    send_beat(4'b0001, {16'd0, 16'd0, 16'd0, 16'd30},
              {32'd0, 32'd0, 32'd0, 32'd1}, 1'b1);
    wait_rows(1);
    pop_row("order_after", 16'd30, 32'd1, 1'b1);
    chk("err_order_sticky", 32'(bus.err_order), 32'd1);
    check_drained("order");

    // Reset mid-beat with a row parked in the output register.
    step();
    bus.out_ready = 1'b0;
    send_beat(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1},
              {32'd40, 32'd30, 32'd20, 32'd10}, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_reset_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    send_beat(4'b0001, {16'd0, 16'd0, 16'd0, 16'd20},
              {32'd0, 32'd0, 32'd0, 32'd33}, 1'b1);
    wait_rows(1);
    pop_row("after_reset", 16'd20, 32'd33, 1'b1);
    check_drained("after_reset");
    chk("after_reset_err_order", 32'(bus.err_order), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spmv_row_accumulator.md
SPMV_ROW_ACCUMULATOR -- requirements
Module: spmv_row_accumulator

Interface
REQ-001 SHALL have parameter NETWORK_WIDTH, default 4, number of input lanes per beat (even, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, two's-complement fixed-point value width.
REQ-003 SHALL have parameter ID_WIDTH, default 16, row-ID width.
REQ-004 SHALL have ports as follows; one clock, reset asynchronous active-high:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous active-high reset
  in_valid  in  1  input beat valid
  in_ready  out  1  beat accepted when in_valid & in_ready
  in_lane_valid  in  NETWORK_WIDTH  per-lane occupancy mask of the beat
  in_data  in  NETWORK_WIDTH*DATA_WIDTH  lane partial sums, lane 0 in LSBs
  in_id  in  NETWORK_WIDTH*ID_WIDTH  lane row IDs, lane 0 in LSBs
  in_last  in  1  beat is final beat of the matrix
  out_valid  out  1  completed row available
  out_ready  in  1  downstream accepts row
  out_data  out  DATA_WIDTH  completed row sum
  out_id  out  ID_WIDTH  completed row ID
  out_last  out  1  row is final row of the matrix
  busy  out  1  beat held or accumulator open
  err_order  out  1  sticky: row ID decreased

Function
REQ-005 SHALL register an accepted beat (mask, data, ids, last) into a single beat buffer.
REQ-006 SHALL be in states IDLE (buffer empty), SCAN (lanes pending), FLUSH (emit open row after last beat).
REQ-007 SHALL in SCAN consume one valid lane per cycle, lowest index first, skipping mask-0 lanes (beat takes popcount(mask) cycles).
REQ-008 SHALL, with no row open, open a row with the lane's id and data.
REQ-009 SHALL, with a row open and equal id, add lane data to the accumulator, result modulo 2^DATA_WIDTH.
REQ-010 SHALL, with a row open and different id, load the open row into the output register and open a new row from the lane in the same cycle.
REQ-011 SHALL stall the scan (lane not consumed) when an emission is required and out_valid=1 & out_ready=0.
REQ-012 SHALL allow output register reload in the same cycle out_ready accepts the current row.
REQ-013 SHALL present an emitted row on out_valid the cycle after the emitting lane is consumed; out_* stable while out_valid & !out_ready.
REQ-014 SHALL assert in_ready in IDLE, or in SCAN when the final pending lane is consumed without stall and the held beat has in_last=0.
REQ-015 SHALL, after the last lane of an in_last beat, enter FLUSH, emit the open row with out_last=1, then return to IDLE.
REQ-016 SHALL, for an in_last beat with zero mask and no open row, return to IDLE without emission; with an open row, FLUSH as REQ-015.
REQ-017 SHALL set err_order when a lane id is less than the open row id; the lane is still processed per REQ-010.
REQ-018 SHALL drive busy = (state != IDLE) | row_open.

Reset
REQ-019 SHALL on rst clear: in_ready=0 while asserted, out_valid=0, out_data=0, out_id=0, out_last=0, busy=0, err_order=0, row closed, state IDLE.
REQ-020 SHALL discard held beat and partial row when reset asserts mid-operation; in_ready=1 the first cycle after deassertion.

Configuration
REQ-021 SHALL, with SPMV_ROW_ACC_SATURATE_EN defined, saturate accumulation to the signed DATA_WIDTH max/min; without it, wrap per REQ-009.

Structure
REQ-022 SHALL take the state enum (IDLE/SCAN/FLUSH) from shared package spmv_pkg.
REQ-023 SHALL instantiate one sub-module spmv_lane_picker: given remaining mask, returns lowest set index and a none-left flag, combinational.

Verification
REQ-024 Beat mask 1111, ids 5,5,5,5, data 1,2,3,4, in_last=1 -> single row id 5, data 10, out_last=1.
REQ-025 Beat mask 1011, ids 2,3,x,3, data 7,1,x,4, last=0; then mask 0001 id 3 data 2, last=1 -> rows (2,7,last0), (3,7,last1); x lanes ignored.
REQ-026 Emission pending with out_ready=0 for 5 cycles -> scan stalls, out_* unchanged, no row lost or duplicated.
REQ-027 Data 0x7FFFFFFF + 1 same id -> 0x80000000 without macro; 0x7FFFFFFF with SPMV_ROW_ACC_SATURATE_EN.
REQ-028 ids 9 then 4 -> err_order=1 sticky; rows 9 and 4 both emitted; rst pulse mid-beat -> all outputs 0, next beat handled cleanly.
